// File: rtl/lights_pkg.sv
// lights_pkg: state encoding, default pulse timing and word width for the LED strip serializer
package lights_pkg;
  localparam int LIGHT_W     = 24;
  localparam int T0H_DEF     = 4;
  localparam int T0L_DEF     = 8;
  localparam int T1H_DEF     = 8;
  localparam int T1L_DEF     = 4;
  localparam int RES_DEF     = 50;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;
  function automatic int max5(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    m = (d > m) ? d : m;
    m = (e > m) ? e : m;
    return m;
  endfunction
endpackage

// File: rtl/bit_timer.sv
// bit_timer: reloadable down-counter that flags when the current phase has run its course
module bit_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  logic [W-1:0] cnt;
  // Reload on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= load ? load_val : (en && cnt != '0) ? cnt - 1'b1 : cnt;
  assign done = cnt == '0;
endmodule

// File: rtl/light_serializer.sv
// light_serializer: sends one 24-bit RGB word per handshake as WS2812-style pulse-width-coded bits
module light_serializer
  import lights_pkg::*;
#(
  parameter int T0H        = T0H_DEF,
  parameter int T0L        = T0L_DEF,
  parameter int T1H        = T1H_DEF,
  parameter int T1L        = T1L_DEF,
  parameter int RES_CYCLES = RES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LIGHT_W-1:0] light,
  input  logic               valid,
  output logic               ready,
  output logic               dout,
  output logic               busy
);
  localparam int CNT_W = $clog2(max5(T0H, T0L, T1H, T1L, RES_CYCLES)) + 1;
  localparam int BIT_W = $clog2(LIGHT_W);
  localparam logic [CNT_W-1:0] L_T0H = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] L_T0L = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0] L_T1H = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] L_T1L = CNT_W'(T1L - 1);
  // The idle cycle in which ready is seen high is itself a low cycle, so LATCH
  // holds one cycle less and a held-valid back-to-back frame sees exactly
  // RES_CYCLES of low line between its last bit and the next rising edge.
  localparam logic [CNT_W-1:0] L_RES = CNT_W'(RES_CYCLES - 2);

  state_t             state;
  logic [LIGHT_W-1:0] shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic               accept;
  logic               load;
  logic               done;
  logic [CNT_W-1:0]   load_val;

  assign ready  = state == IDLE;
  assign busy   = ~ready;
  assign accept = ready && valid;

  // Timer reload value for whichever phase the FSM enters on this edge
  always_comb begin
    load     = accept || (done && state != IDLE);
    load_val = (state == IDLE) ? (light[LIGHT_W-1] ? L_T1H : L_T0H) :
               (state == HIGH) ? (shreg[LIGHT_W-1] ? L_T1L : L_T0L) :
               (state == LOW)  ? ((bit_cnt != '0) ? (shreg[LIGHT_W-2] ? L_T1H : L_T0H) : L_RES) :
                                 '0;
  end

  bit_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (busy),
    .done     (done)
  );

  // Frame FSM: owns the shift register, bit counter and registered line output
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      dout    <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (valid) begin
            shreg   <= light;
            bit_cnt <= BIT_W'(LIGHT_W - 1);
            state   <= HIGH;
            dout    <= 1'b1;
          end
        HIGH:
          if (done) begin
            state <= LOW;
            dout  <= 1'b0;
          end
        LOW:
          if (done && bit_cnt != '0) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 1'b1;
            state   <= HIGH;
            dout    <= 1'b1;
          end else if (done) begin
            state <= LATCH;
          end
        LATCH:
          if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_light_serializer.sv
// tb_light_serializer: directed checks of pulse timing, handshake and async reset
module tb_light_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] light = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        dout;
  logic        busy;
  int          checks = 0;
  int          failures = 0;
  logic        td [0:339];
  logic        tr [0:339];
  logic [23:0] dec;
  int          werr;
  int          lat1;
  int          rz;

  light_serializer dut (
    .clk   (clk),
    .rst   (rst),
    .light (light),
    .valid (valid),
    .ready (ready),
    .dout  (dout),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one word, trace 340 cycles after the accept edge, then decode bit widths
  task automatic frame(input logic [23:0] w, input logic [23:0] w2, input int chg_k, input int pulse_k, input logic hold);
    @(negedge clk);
    light = w;
    valid = 1'b1;
    for (int k = 0; k < 340; k++) begin
      @(negedge clk);
      td[k] = dout;
      tr[k] = ready;
      if (k == 0) valid = hold;
      if (k == chg_k) light = w2;
      if (k == pulse_k) valid = 1'b1;
      if (k == pulse_k + 1) valid = hold;
    end
    dec  = '0;
    werr = 0;
    for (int i = 0; i < 24; i++) begin
      int h;
      int n;
      h = 0;
      n = 0;
      for (int j = 0; j < 12; j++)
        if (td[12*i+j]) begin
          n++;
          if (j == h) h++;
        end
      if (n != h || (h != 8 && h != 4)) werr++;
      dec = {dec[22:0], h == 8};
    end
    lat1 = 0;
    for (int k = 288; k < 338; k++) lat1 += int'(td[k]);
    rz = 0;
    for (int k = 0; k < 337; k++) if (!tr[k]) rz++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 500), 1);
  endtask

  initial begin
    int e;
    // 1: reset held with random inputs, then released
    e = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      light = 24'($urandom);
      valid = 1'($urandom_range(0, 1));
      #1;
      if (dout !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) e++;
    end
    check("rst_hold", 32'(e), 0);
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;
    e = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dout !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) e++;
    end
    check("rst_release", 32'(e), 0);
    check("idle_dout", 32'(dout), 0);
    check("idle_ready", 32'(ready), 1);
    check("idle_busy", 32'(busy), 0);

    // 2: all ones
    frame(24'hFFFFFF, 24'hFFFFFF, -10, -10, 1'b0);
    check("ff_first", 32'(td[0]), 1);
    check("ff_word", 32'(dec), 32'hFFFFFF);
    check("ff_width", 32'(werr), 0);
    check("ff_hi8", 32'(td[7]), 1);
    check("ff_lo_at8", 32'(td[8]), 0);
    check("ff_ready_low", 32'(rz), 337);
    check("ff_ready_back", 32'(tr[337]), 1);
    check("ff_no_refire", 32'(td[338]), 0);

    // 3: all zeros
    frame(24'h000000, 24'h000000, -10, -10, 1'b0);
    check("z_word", 32'(dec), 0);
    check("z_width", 32'(werr), 0);
    check("z_hi4", 32'(td[3]), 1);
    check("z_lo_at4", 32'(td[4]), 0);
    check("z_latch", 32'(lat1), 0);
    check("z_ready_low", 32'(rz), 337);

    // 4: mixed word with light changed during bit 10
    frame(24'hA50F3C, 24'h123456, 120, -10, 1'b0);
    check("mix_word", 32'(dec), 32'hA50F3C);
    check("mix_width", 32'(werr), 0);
    check("mix_latch", 32'(lat1), 0);

    // 5: stray valid while busy, then valid held for back-to-back
    frame(24'h3C3C3C, 24'h3C3C3C, -10, 99, 1'b1);
    check("b2b_word", 32'(dec), 32'h3C3C3C);
    check("b2b_width", 32'(werr), 0);
    check("b2b_ready_low", 32'(rz), 337);
    check("b2b_gap", 32'(lat1), 0);
    check("b2b_gap_end", 32'(td[337]), 0);
    check("b2b_start", 32'(td[338]), 1);
    check("b2b_busy", 32'(tr[338]), 0);
    valid = 1'b0;
    wait_idle();

    // 6: async reset in the middle of a high phase
    @(negedge clk);
    light = 24'hFFFFFF;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (150) @(negedge clk);
    check("mid_dout", 32'(dout), 1);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("arst_dout", 32'(dout), 0);
    check("arst_ready", 32'(ready), 1);
    check("arst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    frame(24'h5A5A5A, 24'h5A5A5A, -10, -10, 1'b0);
    check("post_word", 32'(dec), 32'h5A5A5A);
    check("post_width", 32'(werr), 0);
    check("post_ready", 32'(tr[337]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
